sad_engine: RTL and testbench

- Parametrised successor to the fixed 256-pixel SAD controller: one block holds both control and datapath.
- Computes the sum of absolute differences between two pixel blocks.
- Processes LANES pixel pairs per beat and tolerates a configurable memory read latency.
- Optional early termination aborts a block once its running SAD exceeds a threshold; used in motion search to reject poor candidates quickly.

---
 rtl/sad_engine.sv | 111 +++++++++++
 tb/tb_sad_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sad_engine.sv
// Sum-of-absolute-differences engine: issues BEATS reads of LANES pixel pairs,
// accumulates |a-b| as data returns RD_LAT cycles later, optional early abort.
module sad_engine #(
  parameter int PIXEL_W = 8,
  parameter int NPIX    = 256,
  parameter int LANES   = 1,
  parameter int RD_LAT  = 1,
  localparam int BEATS  = NPIX / LANES,
  localparam int AW     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int SAD_W  = PIXEL_W + $clog2(NPIX)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic                     thresh_en,
  input  logic [SAD_W-1:0]         thresh,
  output logic                     rd_en,
  output logic [AW-1:0]            addr,
  input  logic [LANES*PIXEL_W-1:0] a_data,
  input  logic [LANES*PIXEL_W-1:0] b_data,
  output logic                     busy,
  output logic                     done,
  output logic [SAD_W-1:0]         sad,
  output logic                     early_term
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [RD_LAT-1:0] VTOP = RD_LAT'(1) << (RD_LAT - 1);

  state_t              r_state, w_state_next;
  logic [AW-1:0]       r_addr;
  logic [RD_LAT-1:0]   r_vpipe;
  logic [SAD_W-1:0]    r_acc, r_sad, r_thresh;
  logic                r_thresh_en, r_early;

  logic                w_rd_en, w_beat_valid, w_more, w_hit, w_last;
  logic [SAD_W-1:0]    w_beat_sum, w_acc_next;

  assign w_rd_en      = (r_state == S_ISSUE);
  assign w_beat_valid = r_vpipe[RD_LAT-1];
  // Beats still in flight behind the one returning this cycle.
  assign w_more       = |(r_vpipe & ~VTOP);
  assign w_last       = (r_addr == AW'(BEATS - 1));

  always_comb begin
    w_beat_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (a_data[k*PIXEL_W +: PIXEL_W] >= b_data[k*PIXEL_W +: PIXEL_W])
        w_beat_sum = w_beat_sum + SAD_W'(a_data[k*PIXEL_W +: PIXEL_W] - b_data[k*PIXEL_W +: PIXEL_W]);
      else
        w_beat_sum = w_beat_sum + SAD_W'(b_data[k*PIXEL_W +: PIXEL_W] - a_data[k*PIXEL_W +: PIXEL_W]);
    end
  end

  assign w_acc_next = r_acc + (w_beat_valid ? w_beat_sum : '0);
  assign w_hit      = w_beat_valid && r_thresh_en && (w_acc_next > r_thresh);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (go) w_state_next = S_ISSUE;
      S_ISSUE: if (w_hit || w_last) w_state_next = S_DRAIN;
      S_DRAIN: if (w_hit || !w_more) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_vpipe     <= '0;
      r_acc       <= '0;
      r_sad       <= '0;
      r_thresh    <= '0;
      r_thresh_en <= 1'b0;
      r_early     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // An abort flushes the return pipeline so late beats are never added.
      r_vpipe <= w_hit ? '0 : ((r_vpipe << 1) | RD_LAT'(w_rd_en));
      if (w_beat_valid)
        r_acc <= w_acc_next;
      case (r_state)
        S_IDLE: if (go) begin
          r_acc       <= '0;
          r_addr      <= '0;
          r_thresh    <= thresh;
          r_thresh_en <= thresh_en;
          r_early     <= 1'b0;
        end
        S_ISSUE: r_addr <= w_last ? '0 : r_addr + 1'b1;
        default: ;
      endcase
      if (w_hit)
        r_early <= 1'b1;
      if (r_state == S_DRAIN && w_state_next == S_DONE)
        r_sad <= w_acc_next;
    end
  end

  assign rd_en      = w_rd_en;
  assign addr       = r_addr;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign sad        = r_sad;
  assign early_term = r_early;

endmodule

// File: tb/tb_sad_engine.sv
// Directed bench for sad_engine: a default instance and a 4-lane, 3-cycle
// latency instance, each fed by a latency-matched memory model.
module tb_sad_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Default instance: SAD_W=16, AW=8
  logic        go1, ten1, rd_en1, busy1, done1, et1;
  logic [15:0] th1, sad1;
  logic [7:0]  addr1, a1, b1;
  // 4-lane instance: NPIX=64, SAD_W=14, AW=4
  logic        go2, ten2, rd_en2, busy2, done2, et2;
  logic [13:0] th2, sad2;
  logic [3:0]  addr2;
  logic [31:0] a2, b2;

  sad_engine u_dut1 (
    .clk(clk), .rst(rst), .go(go1), .thresh_en(ten1), .thresh(th1),
    .rd_en(rd_en1), .addr(addr1), .a_data(a1), .b_data(b1),
    .busy(busy1), .done(done1), .sad(sad1), .early_term(et1)
  );

  sad_engine #(.PIXEL_W(8), .NPIX(64), .LANES(4), .RD_LAT(3)) u_dut2 (
    .clk(clk), .rst(rst), .go(go2), .thresh_en(ten2), .thresh(th2),
    .rd_en(rd_en2), .addr(addr2), .a_data(a2), .b_data(b2),
    .busy(busy2), .done(done2), .sad(sad2), .early_term(et2)
  );

  // Memory model: valid pixels only in the cycle a beat is due, noise otherwise.
  logic [7:0]  pa1, pb1;
  logic        sh1;
  logic [2:0]  sh2;
  localparam logic [31:0] A2 = {8'd50, 8'd40, 8'd30, 8'd20};
  localparam logic [31:0] B2 = {8'd54, 8'd37, 8'd32, 8'd19};

  always @(posedge clk) begin
    sh1 <= rd_en1;
    sh2 <= {sh2[1:0], rd_en2};
  end

  always @(negedge clk) begin
    a1 = sh1 ? pa1 : 8'($urandom);
    b1 = sh1 ? pb1 : 8'($urandom);
    a2 = sh2[2] ? A2 : $urandom;
    b2 = sh2[2] ? B2 : $urandom;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Start one block on the selected instance and observe it until idle.
  task automatic run(input int sel, input logic ten, input int th,
                     output int done_cyc, output int ndone, output int nrd,
                     output int addr_bad, output longint s, output logic et);
    done_cyc = 0; ndone = 0; nrd = 0; addr_bad = 0; s = -1; et = 1'b0;
    @(negedge clk);
    if (sel == 1) begin go1 = 1'b1; ten1 = ten; th1 = 16'(th); end
    else          begin go2 = 1'b1; ten2 = ten; th2 = 14'(th); end
    @(posedge clk);
    #1 go1 = 1'b0; go2 = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (sel == 1) begin
        if (rd_en1) begin if (int'(addr1) != nrd) addr_bad++; nrd++; end
        if (done1) begin ndone++; if (done_cyc == 0) begin done_cyc = n; s = sad1; et = et1; end end
        if (done_cyc != 0 && !busy1) break;
      end else begin
        if (rd_en2) begin if (int'(addr2) != nrd) addr_bad++; nrd++; end
        if (done2) begin ndone++; if (done_cyc == 0) begin done_cyc = n; s = sad2; et = et2; end end
        if (done_cyc != 0 && !busy2) break;
      end
    end
  endtask

  typedef struct {
    int         sel;
    logic [7:0] pa, pb;
    logic       ten;
    int         th;
    longint     sad;
    logic       et;
    int         lo, hi;
    int         nrd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int dc, nd, nr, ab, d1, d2;
    longint s;
    logic e;

    vecs[0] = '{1, 8'd10,  8'd3,   1'b0, 0,     1792,  1'b0, 258, 258, 256};
    vecs[1] = '{1, 8'd0,   8'd255, 1'b0, 0,     65280, 1'b0, 258, 258, 256};
    vecs[2] = '{1, 8'd7,   8'd7,   1'b0, 0,     0,     1'b0, 258, 258, 256};
    vecs[3] = '{1, 8'd10,  8'd3,   1'b1, 100,   105,   1'b1, 17,  19,  16};
    vecs[4] = '{1, 8'd255, 8'd0,   1'b1, 65280, 65280, 1'b0, 258, 258, 256};
    vecs[5] = '{1, 8'd10,  8'd3,   1'b1, 1791,  1792,  1'b1, 258, 260, 256};
    vecs[6] = '{2, 8'd0,   8'd0,   1'b0, 0,     160,   1'b0, 20,  20,  16};
    vecs[7] = '{2, 8'd0,   8'd0,   1'b1, 35,    40,    1'b1, 8,   10,  7};

    rst = 1'b0; go1 = 1'b0; go2 = 1'b0; ten1 = 1'b0; ten2 = 1'b0;
    th1 = '0; th2 = '0; pa1 = '0; pb1 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy1", busy1, 0); chk("rst done1", done1, 0); chk("rst sad1", sad1, 0);
    chk("rst et1", et1, 0);     chk("rst rd_en1", rd_en1, 0); chk("rst addr1", addr1, 0);
    chk("rst busy2", busy2, 0); chk("rst done2", done2, 0); chk("rst sad2", sad2, 0);
    chk("rst et2", et2, 0);     chk("rst rd_en2", rd_en2, 0); chk("rst addr2", addr2, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      pa1 = vecs[i].pa; pb1 = vecs[i].pb;
      run(vecs[i].sel, vecs[i].ten, vecs[i].th, dc, nd, nr, ab, s, e);
      chk($sformatf("v%0d sad", i), s, vecs[i].sad);
      chk($sformatf("v%0d early", i), e, vecs[i].et);
      chk_rng($sformatf("v%0d done_cycle", i), dc, vecs[i].lo, vecs[i].hi);
      chk($sformatf("v%0d done_count", i), nd, 1);
      chk($sformatf("v%0d rd_cycles", i), nr, vecs[i].nrd);
      chk($sformatf("v%0d addr_errs", i), ab, 0);
      repeat (2) @(negedge clk);
    end

    // go pulses during ISSUE and DONE must be dropped
    pa1 = 8'd10; pb1 = 8'd3; ten1 = 1'b0;
    @(negedge clk) go1 = 1'b1;
    @(posedge clk); #1 go1 = 1'b0;
    nd = 0;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      if (done1) nd++;
      go1 = (n == 50) || done1;
    end
    go1 = 1'b0;
    chk("ignore done_count", nd, 1);
    chk("ignore busy", busy1, 0);
    chk("ignore sad", sad1, 1792);

    // go held high: back-to-back blocks
    @(negedge clk) go1 = 1'b1;
    @(posedge clk);
    d1 = 0; d2 = 0;
    for (int n = 1; n <= 800; n++) begin
      @(negedge clk);
      if (done1) begin
        if (d1 == 0) d1 = n;
        else begin d2 = n; go1 = 1'b0; break; end
      end
    end
    go1 = 1'b0;
    for (int n = 0; n < 400 && busy1; n++) @(negedge clk);
    chk("held first_done", d1, 258);
    chk("held spacing", d2 - d1, 259);
    chk("held idle_after", busy1, 0);

    // reset during ISSUE beat 100, then a clean block
    pa1 = 8'd10; pb1 = 8'd3;
    @(negedge clk) go1 = 1'b1;
    @(posedge clk); #1 go1 = 1'b0;
    for (int n = 1; n <= 101; n++) @(negedge clk);
    chk("pre-rst addr", addr1, 100);
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy1, 0);   chk("midrst done", done1, 0);
    chk("midrst sad", sad1, 0);     chk("midrst early", et1, 0);
    chk("midrst rd_en", rd_en1, 0); chk("midrst addr", addr1, 0);
    pa1 = 8'd0; pb1 = 8'd255;
    run(1, 1'b0, 0, dc, nd, nr, ab, s, e);
    chk("post-rst sad", s, 65280);
    chk("post-rst early", e, 0);
    chk("post-rst done_cycle", dc, 258);
    chk("post-rst rd_cycles", nr, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
